// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
// Receive-side bit recovery for the UART core. The serial line is passed
// through a two-flop synchroniser, the start bit is detected and qualified,
// and every bit is recovered by a 2-of-3 majority vote over the three
// strobes around the middle of the bit. The acquisition strobe comes from
// the baudrate generator, N strobes per bit.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   AcqSig_i     1-clk acquisition strobe (may be held high: one step per clk)
//   AcqNum_i     strobes per bit N; values below MIN_ACQ are raised to MIN_ACQ
//   ParityEn_i   parity bit follows the data bits
//   ParityOdd_i  odd parity when 1, even parity when 0
//   Rx_i         asynchronous serial input, idle high
//   RxData_o     received character, LSB aligned, unused high bits zero
//   RxValid_o    1-clk pulse when RxData_o and the status flags are updated
//   ParityErr_o  parity mismatch of the last character (held)
//   FrameErr_o   stop bit voted 0 for the last character (held)
module uart_rx_oversampler #(
  parameter int DATA_BITS = 8,
  parameter int MIN_ACQ   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       AcqSig_i,
  input  logic [4:0] AcqNum_i,
  input  logic       ParityEn_i,
  input  logic       ParityOdd_i,
  input  logic       Rx_i,
  output logic [7:0] RxData_o,
  output logic       RxValid_o,
  output logic       ParityErr_o,
  output logic       FrameErr_o
);

  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Synchroniser
  logic sync_reg, rxs_reg;

  // Frame configuration, frozen at start detection
  logic [4:0] n_reg;
  logic       par_en_reg, par_odd_reg;

  // Bit timing and vote
  logic [4:0]           s_reg;
  logic                 samp0_reg, samp1_reg;
  logic [CW-1:0]        bit_cnt_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 par_err_reg;
  logic                 armed_reg;

  // Decoded controls
  logic [4:0] acq_clamped;
  logic [4:0] mid;
  logic       at_v0, at_v1, at_vote, bit_end, last_data, voted;
  logic       load_cfg, take_s0, take_s1, shift_en, par_chk, deliver, arm_set;
  logic [7:0] data_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 1'b1;
      rxs_reg  <= 1'b1;
    end else begin
      sync_reg <= Rx_i;
      rxs_reg  <= sync_reg;
    end
  end

  assign acq_clamped = (AcqNum_i < 5'(MIN_ACQ)) ? 5'(MIN_ACQ) : AcqNum_i;

  // With N >= 4 the three vote samples m-1, m, m+1 always fit inside the bit;
  // for N = 4 the vote and the end of the bit fall on the same strobe.
  assign mid       = n_reg >> 1;
  assign at_v0     = (s_reg == mid - 5'd1);
  assign at_v1     = (s_reg == mid);
  assign at_vote   = (s_reg == mid + 5'd1);
  assign bit_end   = (s_reg == n_reg - 5'd1);
  assign last_data = (bit_cnt_reg == CW'(DATA_BITS - 1));

  // The third sample is the live synchronised value at s = m+1
  assign voted = (samp0_reg & samp1_reg) | (samp0_reg & rxs_reg) | (samp1_reg & rxs_reg);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (AcqSig_i) begin
      case (state_reg)
        IDLE:    if (!rxs_reg && armed_reg) state_next = START;
        START: begin
          if (at_vote && voted) state_next = IDLE;
          else if (bit_end)     state_next = DATA;
        end
        DATA:    if (bit_end && last_data) state_next = par_en_reg ? PARITY : STOP;
        PARITY:  if (bit_end) state_next = STOP;
        STOP:    if (at_vote) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Control decode
  always_comb begin
    load_cfg = 1'b0;
    take_s0  = 1'b0;
    take_s1  = 1'b0;
    shift_en = 1'b0;
    par_chk  = 1'b0;
    deliver  = 1'b0;
    arm_set  = 1'b0;
    if (AcqSig_i) begin
      if (state_reg == IDLE) begin
        load_cfg = !rxs_reg && armed_reg;
        arm_set  = rxs_reg;
      end else begin
        take_s0 = at_v0;
        take_s1 = at_v1;
      end
      shift_en = (state_reg == DATA)   && at_vote;
      par_chk  = (state_reg == PARITY) && at_vote;
      deliver  = (state_reg == STOP)   && at_vote;
    end
  end

  // Sample counter, vote samples, configuration latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_reg       <= '0;
      samp0_reg   <= 1'b1;
      samp1_reg   <= 1'b1;
      n_reg       <= 5'(MIN_ACQ);
      par_en_reg  <= 1'b0;
      par_odd_reg <= 1'b0;
      bit_cnt_reg <= '0;
      par_err_reg <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      if (load_cfg) begin
        // The detecting strobe is s = 0, so the next one is s = 1
        s_reg       <= 5'd1;
        n_reg       <= acq_clamped;
        par_en_reg  <= ParityEn_i;
        par_odd_reg <= ParityOdd_i;
        bit_cnt_reg <= '0;
        par_err_reg <= 1'b0;
      end else if (AcqSig_i && state_reg != IDLE) begin
        s_reg <= bit_end ? 5'd0 : s_reg + 5'd1;
        if (state_reg == DATA && bit_end && !last_data)
          bit_cnt_reg <= bit_cnt_reg + CW'(1);
      end
      if (take_s0) samp0_reg <= rxs_reg;
      if (take_s1) samp1_reg <= rxs_reg;
      if (par_chk) par_err_reg <= voted ^ (^data_reg) ^ par_odd_reg;
      // A break (stop voted 0) disarms until the line is seen idle again
      if (deliver && !voted) armed_reg <= 1'b0;
      else if (arm_set)      armed_reg <= 1'b1;
    end
  end

  // Data bits, one flop per position
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_data
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          data_reg[gi] <= 1'b0;
        else if (load_cfg)
          data_reg[gi] <= 1'b0;
        else if (shift_en && bit_cnt_reg == CW'(gi))
          data_reg[gi] <= voted;
      end
    end
  endgenerate

  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = data_reg;
  end

  // Output registers, updated at the stop-bit vote
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RxValid_o   <= 1'b0;
      RxData_o    <= '0;
      ParityErr_o <= 1'b0;
      FrameErr_o  <= 1'b0;
    end else begin
      RxValid_o <= deliver;
      if (deliver) begin
        RxData_o    <= data_ext;
        ParityErr_o <= par_en_reg & par_err_reg;
        FrameErr_o  <= ~voted;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Self-checking bench for uart_rx_oversampler: a table of single frames
// followed by hand-written glitch, break, back-to-back and reset sequences.
module tb_uart_rx_oversampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       AcqSig_i;
  logic [4:0] AcqNum_i;
  logic       ParityEn_i;
  logic       ParityOdd_i;
  logic       Rx_i;
  logic [7:0] RxData_o;
  logic       RxValid_o;
  logic       ParityErr_o;
  logic       FrameErr_o;

  uart_rx_oversampler #(.DATA_BITS(8), .MIN_ACQ(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .AcqSig_i    (AcqSig_i),
    .AcqNum_i    (AcqNum_i),
    .ParityEn_i  (ParityEn_i),
    .ParityOdd_i (ParityOdd_i),
    .Rx_i        (Rx_i),
    .RxData_o    (RxData_o),
    .RxValid_o   (RxValid_o),
    .ParityErr_o (ParityErr_o),
    .FrameErr_o  (FrameErr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [4:0] acq;
    int         nb;     // strobes per bit as the bench sends them
    int         p;      // clocks per strobe period
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    logic       chg;    // change AcqNum_i during the frame
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         c;
  } pulse_t;

  pulse_t pq[$];
  vec_t   vecs[8];
  int     applied = 0;
  int     miscmp  = 0;
  int     mark_cyc = 0;

  always @(negedge clk) begin
    if (RxValid_o === 1'b1) pq.push_back('{RxData_o, ParityErr_o, FrameErr_o, cyc});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bit of n strobes; Rx changes at the start of the first period and the
  // strobe sits in the last clock of each period. Entered and left at posedge+1.
  task automatic strobe_bit(input logic v, input int n, input int p, input int mark);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < p; c++) begin
        Rx_i     = v;
        AcqSig_i = (c == p - 1);
        if (c == p - 1 && i == mark) mark_cyc = cyc;
        @(posedge clk); #1;
      end
    end
    AcqSig_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb, input int p,
                            input logic pen, input logic pbit, input logic stop,
                            input logic chg);
    strobe_bit(1'b0, nb, p, -1);
    if (chg) AcqNum_i = 5'd6;
    for (int k = 0; k < 8; k++) strobe_bit(d[k], nb, p, -1);
    if (pen) strobe_bit(pbit, nb, p, -1);
    strobe_bit(stop, nb, p, (nb >> 1) + 1);
  endtask

  task automatic check_one(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, "_count"}, pq.size(), 1);
    if (pq.size() > 0) begin
      check({tag, "_data"}, pq[0].d, d);
      check({tag, "_perr"}, pq[0].pe, pe);
      check({tag, "_ferr"}, pq[0].fe, fe);
    end
  endtask

  initial begin
    //          d      acq    nb  p  pen   podd  pbit  stop  chg   exp_d  pe    fe
    vecs[0] = '{8'hA5, 5'd16, 16, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 5'd16, 16, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
    vecs[2] = '{8'h03, 5'd16, 16, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 5'd16, 16, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0};
    vecs[4] = '{8'h01, 5'd16, 16, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h55, 5'd16, 16, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
    vecs[6] = '{8'h96, 5'd7,  7,  4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h96, 1'b0, 1'b0};
    vecs[7] = '{8'h6B, 5'd3,  4,  3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h6B, 1'b0, 1'b0};

    rst = 1'b0; AcqSig_i = 1'b0; AcqNum_i = 5'd16;
    ParityEn_i = 1'b0; ParityOdd_i = 1'b0; Rx_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", RxValid_o, 0);
    check("rst_data", RxData_o, 0);
    check("rst_perr", ParityErr_o, 0);
    check("rst_ferr", FrameErr_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table of single frames
    for (int i = 0; i < 8; i++) begin
      AcqNum_i    = vecs[i].acq;
      ParityEn_i  = vecs[i].pen;
      ParityOdd_i = vecs[i].podd;
      pq.delete();
      strobe_bit(1'b1, vecs[i].nb, vecs[i].p, -1);
      if (i > 0) begin
        check($sformatf("v%0d_hold_perr", i), ParityErr_o, vecs[i-1].exp_pe);
        check($sformatf("v%0d_hold_ferr", i), FrameErr_o, vecs[i-1].exp_fe);
      end
      send_frame(vecs[i].d, vecs[i].nb, vecs[i].p, vecs[i].pen, vecs[i].pbit,
                 vecs[i].stop, vecs[i].chg);
      strobe_bit(1'b1, vecs[i].nb, vecs[i].p, -1);
      check_one($sformatf("v%0d", i), vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      if (pq.size() > 0) check($sformatf("v%0d_timing", i), pq[0].c, mark_cyc + 1);
      $display("vector %0d: sent %02h, %0d pulse(s)", i, vecs[i].d, pq.size());
    end

    // Glitch: three low strobes, then a valid frame
    AcqNum_i = 5'd16; ParityEn_i = 1'b0; ParityOdd_i = 1'b0;
    pq.delete();
    strobe_bit(1'b1, 16, 3, -1);
    strobe_bit(1'b0, 3, 3, -1);
    strobe_bit(1'b1, 16, 3, -1);
    check("glitch_count", pq.size(), 0);
    send_frame(8'h5A, 16, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe_bit(1'b1, 16, 3, -1);
    check_one("glitch_next", 8'h5A, 1'b0, 1'b0);
    $display("glitch: %0d pulse(s) after recovery frame", pq.size());

    // Break: 20 bit times low yields exactly one byte
    pq.delete();
    strobe_bit(1'b0, 16 * 20, 3, -1);
    check_one("break", 8'h00, 1'b0, 1'b1);
    pq.delete();
    strobe_bit(1'b1, 16, 3, -1);
    send_frame(8'h81, 16, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe_bit(1'b1, 16, 3, -1);
    check_one("after_break", 8'h81, 1'b0, 1'b0);
    $display("break: recovery frame gave %0d pulse(s)", pq.size());

    // Clamped N = 4, odd parity, strobe held high, back-to-back frames
    AcqNum_i = 5'd2; ParityEn_i = 1'b1; ParityOdd_i = 1'b1;
    pq.delete();
    strobe_bit(1'b1, 8, 1, -1);
    send_frame(8'hFF, 4, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h00, 4, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h7E, 4, 1, 1'b1, 1'b1, 1'b1, 1'b0);
    strobe_bit(1'b1, 8, 1, -1);
    check("b2b_count", pq.size(), 3);
    if (pq.size() == 3) begin
      check("b2b_d0", pq[0].d, 8'hFF);
      check("b2b_d1", pq[1].d, 8'h00);
      check("b2b_d2", pq[2].d, 8'h7E);
      check("b2b_err", {pq[0].pe, pq[0].fe, pq[1].pe, pq[1].fe, pq[2].pe, pq[2].fe}, 0);
    end
    $display("back-to-back: %0d pulse(s)", pq.size());

    // Reset during data bit 4 of 0x3C
    AcqNum_i = 5'd16; ParityEn_i = 1'b0; ParityOdd_i = 1'b0;
    strobe_bit(1'b1, 16, 3, -1);
    pq.delete();
    strobe_bit(1'b0, 16, 3, -1);
    strobe_bit(1'b0, 16, 3, -1);
    strobe_bit(1'b0, 16, 3, -1);
    strobe_bit(1'b1, 16, 3, -1);
    strobe_bit(1'b1, 16, 3, -1);
    strobe_bit(1'b1, 5, 3, -1);
    rst = 1'b0; Rx_i = 1'b1;
    #1;
    check("mid_rst_data", RxData_o, 0);
    check("mid_rst_flags", {RxValid_o, ParityErr_o, FrameErr_o}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    strobe_bit(1'b1, 32, 3, -1);
    check("post_rst_count", pq.size(), 0);
    check("post_rst_data", RxData_o, 0);
    send_frame(8'h3C, 16, 3, 1'b0, 1'b0, 1'b1, 1'b0);
    strobe_bit(1'b1, 16, 3, -1);
    check_one("post_rst_frame", 8'h3C, 1'b0, 1'b0);
    $display("reset: next frame gave %0d pulse(s)", pq.size());

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule
